// File: rtl/bcd_accum_pkg.sv
// Shared types and helpers for the BCD carry accumulator.
//   bcd_digit_t  : one 4-bit BCD digit
//   BCD_MAX      : largest legal BCD digit value (9)
//   snap_state_t : snapshot handshake FSM states
//   bcd_is_valid : true when a digit is a legal BCD value (0..9)
package bcd_accum_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic {
        SNAP_IDLE  = 1'b0,
        SNAP_VALID = 1'b1
    } snap_state_t;

    function automatic logic bcd_is_valid(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register of the accumulator cascade.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear to 0
//   inc_en     : increment this digit (carry-in from lower digits)
//   sat_hold   : absorb the increment (saturating build at all-9s)
//   digit      : registered digit value
//   at_max     : digit currently equals 9
//   carry_out  : increment request ripples into the next digit
module bcd_digit_cell
    import bcd_accum_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc_en,
    input  logic       sat_hold,
    output bcd_digit_t digit,
    output logic       at_max,
    output logic       carry_out
);

    assign at_max    = (digit == BCD_MAX);
    assign carry_out = inc_en & at_max;

    // Roll to 0 at 9 or above, so a digit can never leave the BCD range.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc_en && !sat_hold) begin
            if (digit >= BCD_MAX) begin
                digit <= '0;
            end else begin
                digit <= digit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_carry_accum.sv
// Accumulates decade-counter carry pulses into DIGITS cascaded BCD digits,
// with a ready/valid snapshot port, sticky overflow and a threshold-hit pulse.
// Build option: define BCD_SAT_EN to saturate at all-9s instead of wrapping.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clr         : clear accumulator, ovf and thr_hit (snapshot untouched)
//   cin         : carry pulse from the decade counter
//   lsd_in      : counter live digit, sampled at snapshot capture
//   thr_in      : BCD threshold
//   snap_req    : snapshot request
//   snap_ready  : consumer accepts snapshot
//   snap_valid  : snapshot held
//   snap_data   : {acc, lsd} captured, MSD first
//   acc_out     : live accumulator
//   ovf         : sticky overflow past all-9s
//   thr_hit     : one-cycle pulse on entering acc == thr_in
//   snap_miss   : sticky, request arrived while a snapshot was pending
module bcd_carry_accum
    import bcd_accum_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIG_W  = 4
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      cin,
    input  logic [DIG_W-1:0]          lsd_in,
    input  logic [DIG_W*DIGITS-1:0]   thr_in,
    input  logic                      snap_req,
    input  logic                      snap_ready,
    output logic                      snap_valid,
    output logic [DIG_W*(DIGITS+1)-1:0] snap_data,
    output logic [DIG_W*DIGITS-1:0]   acc_out,
    output logic                      ovf,
    output logic                      thr_hit,
    output logic                      snap_miss
);

    localparam int unsigned ACC_W = DIG_W * DIGITS;

    logic [ACC_W-1:0]  acc;
    logic [DIGITS-1:0] inc;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] carry;
    logic              sat_hold;

`ifdef BCD_SAT_EN
    // At all-9s the pulse is absorbed and every digit holds.
    assign sat_hold = &at_max;
`else
    assign sat_hold = 1'b0;
`endif

    // Ripple carry: digit i increments when cin is set and all lower digits are 9.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign inc[i] = cin;
        end else begin : g_upper
            assign inc[i] = carry[i-1];
        end

        bcd_digit_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .inc_en    (inc[i]),
            .sat_hold  (sat_hold),
            .digit     (acc[i*DIG_W +: DIG_W]),
            .at_max    (at_max[i]),
            .carry_out (carry[i])
        );
    end

    assign acc_out = acc;

    // Carry out of the top digit means cin arrived at all-9s.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (carry[DIGITS-1]) begin
            ovf <= 1'b1;
        end
    end

    // Threshold compare; a non-BCD threshold can never match.
    logic thr_ok_c;
    logic acc_eq_c;
    logic acc_eq_q;

    always_comb begin
        thr_ok_c = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!bcd_is_valid(thr_in[i*DIG_W +: DIG_W])) begin
                thr_ok_c = 1'b0;
            end
        end
        acc_eq_c = thr_ok_c && (acc == thr_in);
    end

    // Edge-detect on equality; on clr remember the pre-clear compare so a
    // clear only pulses when the cleared value newly matches.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_hit  <= 1'b0;
            acc_eq_q <= 1'b0;
        end else if (clr) begin
            thr_hit  <= 1'b0;
            acc_eq_q <= acc_eq_c;
        end else begin
            thr_hit  <= acc_eq_c & ~acc_eq_q;
            acc_eq_q <= acc_eq_c;
        end
    end

    // Snapshot handshake FSM.
    snap_state_t state;
    snap_state_t state_nxt;
    logic        capture;
    logic        miss_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SNAP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        miss_set  = 1'b0;
        case (state)
            SNAP_IDLE: begin
                if (snap_req) begin
                    state_nxt = SNAP_VALID;
                    capture   = 1'b1;
                end
            end
            SNAP_VALID: begin
                if (snap_ready) begin
                    if (snap_req) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = SNAP_IDLE;
                    end
                end else if (snap_req) begin
                    miss_set = 1'b1;
                end
            end
            default: state_nxt = SNAP_IDLE;
        endcase
    end

    assign snap_valid = (state == SNAP_VALID);

    // Capture uses the pre-edge accumulator, so cin or clr in the same cycle is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_data <= '0;
            snap_miss <= 1'b0;
        end else begin
            if (capture) begin
                snap_data <= {acc, lsd_in};
            end
            if (miss_set) begin
                snap_miss <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_carry_accum.sv
module tb_bcd_carry_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        cin;
    logic [3:0]  lsd_in;
    logic [15:0] thr_in;
    logic        snap_req;
    logic        snap_ready;
    logic        snap_valid;
    logic [19:0] snap_data;
    logic [15:0] acc_out;
    logic        ovf;
    logic        thr_hit;
    logic        snap_miss;

    int n_vec  = 0;
    int n_miss = 0;

    int acc_m = 0;
    logic ovf_m = 1'b0;
    logic [19:0] snap_q[$];

    bcd_carry_accum #(.DIGITS(4), .DIG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .cin        (cin),
        .lsd_in     (lsd_in),
        .thr_in     (thr_in),
        .snap_req   (snap_req),
        .snap_ready (snap_ready),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .acc_out    (acc_out),
        .ovf        (ovf),
        .thr_hit    (thr_hit),
        .snap_miss  (snap_miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal model of the accumulator, advanced once per cin cycle.
    task automatic model_inc();
        if (acc_m == 9999) begin
`ifdef BCD_SAT_EN
            acc_m = 9999;
`else
            acc_m = 0;
`endif
            ovf_m = 1'b1;
        end else begin
            acc_m = acc_m + 1;
        end
    endtask

    task automatic pulse_cin(input int n);
        cin = 1'b1;
        repeat (n) begin
            tick();
            model_inc();
        end
        cin = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        acc_m = 0;
        ovf_m = 1'b0;
    endtask

    // Scoreboard: every accepted snapshot must match the oldest expected capture.
    always @(negedge clk) begin
        if (!rst && snap_valid && snap_ready) begin
            if (snap_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL snap_unexpected: got %0h, expected none", snap_data);
            end else begin
                check("snap_handshake", 32'(snap_data), 32'(snap_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic        clr_first;
        int          n_cin;
        logic [15:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 0,    16'h0000, 1'b0};
        tbl[1] = '{1'b0, 123,  16'h0123, 1'b0};
        tbl[2] = '{1'b0, 877,  16'h1000, 1'b0};
        tbl[3] = '{1'b0, 8999, 16'h9999, 1'b0};
`ifdef BCD_SAT_EN
        tbl[4] = '{1'b0, 1,    16'h9999, 1'b1};
        tbl[5] = '{1'b0, 5,    16'h9999, 1'b1};
`else
        tbl[4] = '{1'b0, 1,    16'h0000, 1'b1};
        tbl[5] = '{1'b0, 5,    16'h0005, 1'b1};
`endif
        tbl[6] = '{1'b1, 37,   16'h0037, 1'b0};

        rst = 1'b1; clr = 1'b0; cin = 1'b0; lsd_in = 4'd0;
        thr_in = 16'hFFFF; snap_req = 1'b0; snap_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_acc",        32'(acc_out),    32'h0);
        check("rst_ovf",        32'(ovf),        32'h0);
        check("rst_thr_hit",    32'(thr_hit),    32'h0);
        check("rst_snap_valid", 32'(snap_valid), 32'h0);
        check("rst_snap_data",  32'(snap_data),  32'h0);
        check("rst_snap_miss",  32'(snap_miss),  32'h0);

        for (int v = 0; v < 7; v++) begin
            if (tbl[v].clr_first) do_clr();
            pulse_cin(tbl[v].n_cin);
            check($sformatf("vec%0d_acc", v), 32'(acc_out), 32'(tbl[v].exp_acc));
            check($sformatf("vec%0d_ovf", v), 32'(ovf),     32'(tbl[v].exp_ovf));
        end
        check("nonbcd_thr_no_hit", 32'(thr_hit), 32'h0);

        // Snapshot coincident with cin captures the pre-increment value.
        do_clr();
        pulse_cin(42);
        lsd_in = 4'd7; snap_req = 1'b1; cin = 1'b1;
        snap_q.push_back({to_bcd(acc_m), lsd_in});
        tick();
        model_inc();
        snap_req = 1'b0; cin = 1'b0;
        check("snap_valid_1cyc", 32'(snap_valid), 32'h1);
        check("snap_data_00427", 32'(snap_data),  32'h00427);
        check("acc_after_snap",  32'(acc_out),    32'h0043);

        // Consumer stalls; a second request is dropped and flagged.
        for (int k = 0; k < 5; k++) begin
            snap_req = (k == 1);
            tick();
            check($sformatf("snap_hold%0d", k), 32'(snap_data), 32'h00427);
        end
        snap_req = 1'b0;
        check("snap_miss_set",   32'(snap_miss),  32'h1);
        check("snap_still_valid", 32'(snap_valid), 32'h1);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        check("snap_released", 32'(snap_valid), 32'h0);

        // Back-to-back capture during the accepting cycle.
        lsd_in = 4'd3; snap_req = 1'b1;
        snap_q.push_back({to_bcd(acc_m), lsd_in});
        tick();
        lsd_in = 4'd4; snap_ready = 1'b1; cin = 1'b1;
        snap_q.push_back({to_bcd(acc_m), lsd_in});
        tick();
        model_inc();
        cin = 1'b0; snap_req = 1'b0;
        check("b2b_valid", 32'(snap_valid), 32'h1);
        check("b2b_data",  32'(snap_data),  32'h00434);
        tick();
        snap_ready = 1'b0;
        check("b2b_done", 32'(snap_valid), 32'h0);

        // Threshold pulse: exactly one, the cycle after acc reaches 0010.
        begin
            int hits;
            hits = 0;
            thr_in = 16'h0010;
            do_clr();
            cin = 1'b1;
            repeat (10) begin
                tick();
                model_inc();
                if (thr_hit) hits++;
            end
            cin = 1'b0;
            check("thr_acc_0010", 32'(acc_out), 32'h0010);
            tick();
            check("thr_hit_pulse", 32'(thr_hit), 32'h1);
            if (thr_hit) hits++;
            repeat (4) begin
                tick();
                if (thr_hit) hits++;
            end
            check("thr_hit_count", 32'(hits), 32'h1);
            thr_in = 16'hFFFF;
        end

        // clr with cin while overflowed and a snapshot is pending.
        do_clr();
        pulse_cin(10000);
        pulse_cin(15);
        check("pre_clr_ovf", 32'(ovf), 32'h1);
        lsd_in = 4'd5; snap_req = 1'b1;
        snap_q.push_back({to_bcd(acc_m), lsd_in});
        tick();
        snap_req = 1'b0;
        clr = 1'b1; cin = 1'b1;
        tick();
        clr = 1'b0; cin = 1'b0;
        acc_m = 0; ovf_m = 1'b0;
        check("clr_cin_acc", 32'(acc_out),    32'h0);
        check("clr_cin_ovf", 32'(ovf),        32'h0);
        check("clr_snap_valid", 32'(snap_valid), 32'h1);
`ifdef BCD_SAT_EN
        check("clr_snap_data", 32'(snap_data), 32'h99995);
`else
        check("clr_snap_data", 32'(snap_data), 32'h00155);
`endif
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;

        // clr and snap_req together capture the pre-clear value.
        pulse_cin(7);
        clr = 1'b1; snap_req = 1'b1; lsd_in = 4'd1;
        snap_q.push_back({to_bcd(acc_m), lsd_in});
        tick();
        clr = 1'b0; snap_req = 1'b0;
        acc_m = 0;
        check("clr_snap_acc",  32'(acc_out),   32'h0);
        check("clr_snap_pre",  32'(snap_data), 32'h00071);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;

        // Reset mid-handshake drops the pending snapshot.
        pulse_cin(3);
        snap_req = 1'b1;
        snap_q.push_back({to_bcd(acc_m), lsd_in});
        tick();
        snap_req = 1'b0;
        check("pre_rst_valid", 32'(snap_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(snap_q.pop_back());
        acc_m = 0; ovf_m = 1'b0;
        check("rst_mid_valid", 32'(snap_valid), 32'h0);
        check("rst_mid_acc",   32'(acc_out),    32'h0);
        check("rst_mid_miss",  32'(snap_miss),  32'h0);
        check("model_acc_end", 32'(acc_out),    32'(to_bcd(acc_m)));

        tick();
        check("scoreboard_empty", 32'(snap_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
